// File: rtl/axil_rd_arbiter.sv
// axil_rd_arbiter
//   Two AXI4-Lite read masters (s0 = instruction fetch, s1 = data) share one
//   AXI4-Lite read slave (m). Round-robin grant, exactly one read in flight,
//   and every slave-side output comes straight from a register.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   s0_axil_*           master 0 AR/R channels (araddr/arprot/arvalid in, arready out,
//                       rdata/rresp/rvalid out, rready in)
//   s1_axil_*           master 1, same as s0
//   m_axil_*            shared slave AR/R channels (araddr/arprot/arvalid/rready out,
//                       arready/rdata/rresp/rvalid in)
//
// Flow: IDLE (accept a winner) -> ADDR (present AR) -> DATA (wait for R)
//       -> RESP (return to the granted master) -> IDLE.
// The shared slave must be reset by the same rst: a reset mid-read drops the
// read without a response.
module axil_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0 (instruction)
  input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
  input  logic [2:0]            s0_axil_arprot,
  input  logic                  s0_axil_arvalid,
  output logic                  s0_axil_arready,
  output logic [DATA_WIDTH-1:0] s0_axil_rdata,
  output logic [1:0]            s0_axil_rresp,
  output logic                  s0_axil_rvalid,
  input  logic                  s0_axil_rready,
  // master 1 (data)
  input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
  input  logic [2:0]            s1_axil_arprot,
  input  logic                  s1_axil_arvalid,
  output logic                  s1_axil_arready,
  output logic [DATA_WIDTH-1:0] s1_axil_rdata,
  output logic [1:0]            s1_axil_rresp,
  output logic                  s1_axil_rvalid,
  input  logic                  s1_axil_rready,
  // shared slave
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e                state_q;
  logic                  last_grant_q;
  logic                  grant_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [2:0]            arprot_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  s0_rvalid_q;
  logic                  s1_rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic win0, win1, r_hs;

  // A lone requester always wins; on a tie the master that was not granted
  // last time goes. win0/win1 are mutually exclusive by construction.
  assign win0 = s0_axil_arvalid & (~s1_axil_arvalid | last_grant_q);
  assign win1 = s1_axil_arvalid & (~s0_axil_arvalid | ~last_grant_q);

  // Only the AR ready is combinational: the winner is accepted in IDLE only.
  assign s0_axil_arready = (state_q == IDLE) & win0;
  assign s1_axil_arready = (state_q == IDLE) & win1;

  // Both masters see the captured data; only their own rvalid qualifies it.
  assign s0_axil_rdata  = rdata_q;
  assign s0_axil_rresp  = rresp_q;
  assign s0_axil_rvalid = s0_rvalid_q;
  assign s1_axil_rdata  = rdata_q;
  assign s1_axil_rresp  = rresp_q;
  assign s1_axil_rvalid = s1_rvalid_q;

  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = arprot_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

  assign r_hs = (s0_rvalid_q & s0_axil_rready) | (s1_rvalid_q & s1_axil_rready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;  // master 0 wins the first tie
      grant_q      <= 1'b0;
      araddr_q     <= '0;
      arprot_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      s0_rvalid_q  <= 1'b0;
      s1_rvalid_q  <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win0 | win1) begin
            grant_q   <= win1;
            araddr_q  <= win1 ? s1_axil_araddr : s0_axil_araddr;
            arprot_q  <= win1 ? s1_axil_arprot : s0_axil_arprot;
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (m_axil_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (m_axil_rvalid) begin
            rdata_q     <= m_axil_rdata;
            rresp_q     <= m_axil_rresp;  // error responses pass through untouched
            rready_q    <= 1'b0;
            s0_rvalid_q <= ~grant_q;
            s1_rvalid_q <= grant_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (r_hs) begin
            s0_rvalid_q  <= 1'b0;
            s1_rvalid_q  <= 1'b0;
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
